// File: rtl/button_event_generator.sv
`default_nettype none
// ============================================================================
//  Module      : button_event_generator
//  Description : Turns one debounced button level into single-clock event
//                pulses: press, release, short tap, long press and auto-repeat.
//                Sits between the button debouncer and the menu/keypad
//                controller; one instance per button.
//  Ports       : CLK             - block clock, rising edge
//                RST_N           - asynchronous active-low reset
//                CleanButtonIn   - debounced level (polarity by ACTIVE_LOW)
//                PressPulse      - one clock on press detection
//                ReleasePulse    - one clock on every release
//                ShortPressPulse - one clock on release before long threshold
//                LongPressPulse  - one clock when long threshold is reached
//                RepeatPulse     - one clock every REPEAT_CYCLES after long
//                Held            - high while a press is in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module button_event_generator #(
    parameter int unsigned LONG_PRESS_CYCLES = 50000000,
    parameter int unsigned REPEAT_CYCLES     = 10000000,
    parameter bit          REPEAT_EN         = 1'b1,
    parameter bit          ACTIVE_LOW        = 1'b1
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic CleanButtonIn,
    output logic PressPulse,
    output logic ReleasePulse,
    output logic ShortPressPulse,
    output logic LongPressPulse,
    output logic RepeatPulse,
    output logic Held
);

    localparam int unsigned C_CNT_MAX = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ?
                                        LONG_PRESS_CYCLES : REPEAT_CYCLES;
    localparam int          C_CNT_W   = $clog2(C_CNT_MAX);

    localparam logic [C_CNT_W-1:0] C_LONG_LAST = C_CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_REP_LAST  = C_CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ZERO  = '0;
    localparam logic [C_CNT_W-1:0] C_CNT_ONE   = C_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [C_CNT_W-1:0]   r_cnt;
    logic [C_CNT_W-1:0]   w_cnt_nxt;
    logic                 r_prev_btn;
    logic                 w_btn;
    logic                 w_press;
    logic                 w_release;
    logic                 w_short;
    logic                 w_long;
    logic                 w_repeat;

    // Normalise polarity so that 1 always means "pressed".
    assign w_btn = CleanButtonIn ^ ACTIVE_LOW;

    // State, counter and registered outputs. prev_btn resets to "pressed" so a
    // button held through reset release must be let go before it can count.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state         <= ST_IDLE;
            r_cnt           <= C_CNT_ZERO;
            r_prev_btn      <= 1'b1;
            PressPulse      <= 1'b0;
            ReleasePulse    <= 1'b0;
            ShortPressPulse <= 1'b0;
            LongPressPulse  <= 1'b0;
            RepeatPulse     <= 1'b0;
            Held            <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_prev_btn      <= w_btn;
            PressPulse      <= w_press;
            ReleasePulse    <= w_release;
            ShortPressPulse <= w_short;
            LongPressPulse  <= w_long;
            RepeatPulse     <= w_repeat;
            Held            <= (w_state_nxt != ST_IDLE);
        end
    end

    // Next state / counter / pulse decisions. Release is tested first in every
    // pressed state so it always wins over a threshold expiring in that cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_press     = 1'b0;
        w_release   = 1'b0;
        w_short     = 1'b0;
        w_long      = 1'b0;
        w_repeat    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_btn && !r_prev_btn) begin
                    w_state_nxt = ST_PRESSED;
                    w_cnt_nxt   = C_CNT_ZERO;
                    w_press     = 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!w_btn) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = C_CNT_ZERO;
                    w_release   = 1'b1;
                    w_short     = 1'b1;
                end else if (r_cnt == C_LONG_LAST) begin
                    w_state_nxt = ST_LONG;
                    w_cnt_nxt   = C_CNT_ZERO;
                    w_long      = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + C_CNT_ONE;
                end
            end
            ST_LONG: begin
                if (!w_btn) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = C_CNT_ZERO;
                    w_release   = 1'b1;
                end else if (r_cnt == C_REP_LAST) begin
                    // With repeat disabled the counter simply parks here.
                    if (REPEAT_EN) begin
                        w_cnt_nxt = C_CNT_ZERO;
                        w_repeat  = 1'b1;
                    end
                end else begin
                    w_cnt_nxt   = r_cnt + C_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = C_CNT_ZERO;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_button_event_generator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_event_generator
//  Description : Self-checking bench for button_event_generator. Three
//                instances (default, repeat disabled, active-high input)
//                share one logical button and are compared each clock with
//                a press-age based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_event_generator;

    localparam int LP = 8;
    localparam int RP = 4;

    logic CLK;
    logic RST_N;
    logic btn;

    logic [2:0] o_press, o_rel, o_short, o_long, o_rep, o_held;

    int errors;
    int checks;

    // Reference model state, index 0 = repeat enabled, 1 = repeat disabled
    bit m_active [2];
    bit m_prev   [2];
    int m_age    [2];
    bit e_press [2], e_rel [2], e_short [2], e_long [2], e_rep [2], e_held [2];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    button_event_generator #(.LONG_PRESS_CYCLES(LP), .REPEAT_CYCLES(RP),
                             .REPEAT_EN(1'b1), .ACTIVE_LOW(1'b1)) u_a (
        .CLK(CLK), .RST_N(RST_N), .CleanButtonIn(~btn),
        .PressPulse(o_press[0]), .ReleasePulse(o_rel[0]), .ShortPressPulse(o_short[0]),
        .LongPressPulse(o_long[0]), .RepeatPulse(o_rep[0]), .Held(o_held[0]));

    button_event_generator #(.LONG_PRESS_CYCLES(LP), .REPEAT_CYCLES(RP),
                             .REPEAT_EN(1'b0), .ACTIVE_LOW(1'b1)) u_b (
        .CLK(CLK), .RST_N(RST_N), .CleanButtonIn(~btn),
        .PressPulse(o_press[1]), .ReleasePulse(o_rel[1]), .ShortPressPulse(o_short[1]),
        .LongPressPulse(o_long[1]), .RepeatPulse(o_rep[1]), .Held(o_held[1]));

    button_event_generator #(.LONG_PRESS_CYCLES(LP), .REPEAT_CYCLES(RP),
                             .REPEAT_EN(1'b1), .ACTIVE_LOW(1'b0)) u_c (
        .CLK(CLK), .RST_N(RST_N), .CleanButtonIn(btn),
        .PressPulse(o_press[2]), .ReleasePulse(o_rel[2]), .ShortPressPulse(o_short[2]),
        .LongPressPulse(o_long[2]), .RepeatPulse(o_rep[2]), .Held(o_held[2]));

    task automatic chk(input string tag, input int d, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s dut%0d t=%0t observed=%b expected=%b", tag, d, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 3; d++) begin
            int m;
            m = (d == 1) ? 1 : 0;
            chk("press", d, o_press[d], e_press[m]);
            chk("release", d, o_rel[d], e_rel[m]);
            chk("short", d, o_short[d], e_short[m]);
            chk("long", d, o_long[d], e_long[m]);
            chk("repeat", d, o_rep[d], e_rep[m]);
            chk("held", d, o_held[d], e_held[m]);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_active[m] = 1'b0; m_prev[m] = 1'b1; m_age[m] = 0;
            e_press[m] = 1'b0; e_rel[m] = 1'b0; e_short[m] = 1'b0;
            e_long[m] = 1'b0; e_rep[m] = 1'b0; e_held[m] = 1'b0;
        end
    endtask

    // Events are derived from how many edges have passed since the press edge.
    task automatic model_edge(input bit b);
        if (!RST_N) begin
            model_reset();
            return;
        end
        for (int m = 0; m < 2; m++) begin
            e_press[m] = 1'b0; e_rel[m] = 1'b0; e_short[m] = 1'b0;
            e_long[m] = 1'b0; e_rep[m] = 1'b0;
            if (!m_active[m]) begin
                if (b && !m_prev[m]) begin
                    m_active[m] = 1'b1;
                    m_age[m]    = 0;
                    e_press[m]  = 1'b1;
                end
            end else begin
                m_age[m]++;
                if (!b) begin
                    e_rel[m]    = 1'b1;
                    e_short[m]  = (m_age[m] <= LP);
                    m_active[m] = 1'b0;
                end else begin
                    e_long[m] = (m_age[m] == LP);
                    e_rep[m]  = (m == 0) && (m_age[m] > LP) && (((m_age[m] - LP) % RP) == 0);
                end
            end
            m_prev[m] = b;
            e_held[m] = m_active[m];
        end
    endtask

    task automatic step(input bit b);
        btn = b;
        @(posedge CLK);
        model_edge(b);
        #1;
        check_all();
    endtask

    task automatic hold(input bit b, input int n);
        for (int i = 0; i < n; i++) step(b);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        btn    = 1'b0;
        RST_N  = 1'b0;
        model_reset();
        #1;
        check_all();                 // reset state
        hold(1'b0, 2);
        RST_N = 1'b1;
        hold(1'b0, 3);

        // Tap: pressed E0..E2, released at E3
        hold(1'b1, 3);
        step(1'b0);
        hold(1'b0, 3);

        // Hold through long and repeats, release at E20
        hold(1'b1, 20);
        step(1'b0);
        hold(1'b0, 3);

        // Release exactly at the long-press threshold edge (E8)
        hold(1'b1, 8);
        step(1'b0);
        hold(1'b0, 3);

        // Long hold; repeat-disabled instance must saturate silently
        hold(1'b1, 30);
        step(1'b0);
        hold(1'b0, 3);

        // Release one edge after long (release only)
        hold(1'b1, 9);
        step(1'b0);
        hold(1'b0, 2);

        // Reset mid-hold: low between E9 and E10, high before E12
        hold(1'b1, 10);
        #2;
        RST_N = 1'b0;
        model_reset();
        #1;
        check_all();                 // asynchronous clear of outputs
        hold(1'b1, 2);
        RST_N = 1'b1;
        hold(1'b1, 8);
        step(1'b0);                  // E20 release: no event expected
        hold(1'b0, 4);
        step(1'b1);                  // E25 fresh press
        hold(1'b1, 2);
        step(1'b0);
        hold(1'b0, 2);

        // Randomised press/release patterns
        for (int k = 0; k < 40; k++) begin
            hold(1'b0, $urandom_range(1, 4));
            hold(1'b1, $urandom_range(1, 26));
        end
        hold(1'b0, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
